// File: rtl/enemy_pkg.sv
// Shared types and constants for the enemy motion controller: direction and
// life-cycle encodings plus the edge-code bit each direction is blocked by.
package enemy_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_UP    = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_WALK  = 2'd0,
    ST_DYING = 2'd1,
    ST_DEAD  = 2'd2
  } state_t;

  localparam int HIT_LEFT   = 3;
  localparam int HIT_TOP    = 2;
  localparam int HIT_RIGHT  = 1;
  localparam int HIT_BOTTOM = 0;

  // Edge-code bit that stops travel in direction d.
  function automatic logic [1:0] blocking_bit(input dir_t d);
    case (d)
      DIR_RIGHT: blocking_bit = 2'(HIT_RIGHT);
      DIR_DOWN:  blocking_bit = 2'(HIT_BOTTOM);
      DIR_LEFT:  blocking_bit = 2'(HIT_LEFT);
      default:   blocking_bit = 2'(HIT_TOP);
    endcase
  endfunction

endpackage

// File: rtl/enemy_frame_divider.sv
// Modulo-MOVE_PERIOD frame counter; move_tick marks the frame pulse that
// completes a period. clear has priority over counting.
module enemy_frame_divider #(
  parameter int MOVE_PERIOD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic frame_tick,
  output logic move_tick
);

  localparam int CW = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          at_last;

  assign at_last   = (cnt_q == CW'(MOVE_PERIOD - 1));
  assign move_tick = frame_tick & at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (frame_tick) begin
      cnt_d = at_last ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/enemy_move_ctrl.sv
// Per-enemy motion and life-cycle controller: latches collisions over a frame
// and, on each frame pulse, decides to move, turn back, or start dying.
module enemy_move_ctrl
  import enemy_pkg::*;
#(
  parameter int INIT_X       = 64,
  parameter int INIT_Y       = 64,
  parameter int INIT_DIR     = 0,
  parameter int SPEED        = 1,
  parameter int MOVE_PERIOD  = 2,
  parameter int DEATH_FRAMES = 32,
  parameter int X_MIN        = 32,
  parameter int X_MAX        = 576,
  parameter int Y_MIN        = 32,
  parameter int Y_MAX        = 416
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        wallCollision,
  input  logic        bombCollision,
  input  logic [3:0]  HitEdgeCode,
  input  logic        revive,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic        visible,
  output logic        alive,
  output logic [1:0]  dir,
  output logic        deathDone,
  output state_t      dbg_state
);

  state_t      state_q, state_d;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  dir_t        dir_q, dir_d;
  logic [3:0]  hit_q, hit_d;
  logic        bomb_q, bomb_d;
  logic [15:0] death_cnt_q, death_cnt_d;
  logic        done_q, done_d;

  logic        in_walk;
  logic        wall_turn;
  logic        move_tick;
  logic        death_last;
  logic        horiz;
  logic        fwd;
  logic [11:0] mv;

  // Saturating one-step move; returns {hit_bound, new_position}.
  function automatic logic [11:0] step(input logic [10:0] pos, input logic up,
                                       input int lo, input int hi);
    int   p;
    logic sat;
    p   = up ? int'(pos) + SPEED : int'(pos) - SPEED;
    sat = 1'b0;
    if (p > hi) begin
      p   = hi;
      sat = 1'b1;
    end else if (p < lo) begin
      p   = lo;
      sat = 1'b1;
    end
    step = {sat, 11'(p)};
  endfunction

  assign in_walk    = (state_q == ST_WALK);
  assign wall_turn  = in_walk && startOfFrame && !bomb_q && hit_q[blocking_bit(dir_q)];
  assign death_last = (death_cnt_q == 16'(DEATH_FRAMES - 1));

  enemy_frame_divider #(
    .MOVE_PERIOD(MOVE_PERIOD)
  ) u_div (
    .clk       (clk),
    .rst_n     (resetN),
    .clear     (!in_walk || wall_turn),
    .frame_tick(in_walk && startOfFrame && !bomb_q),
    .move_tick (move_tick)
  );

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_WALK;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WALK:  if (startOfFrame && bomb_q) state_d = ST_DYING;
      ST_DYING: if (startOfFrame && death_last) state_d = ST_DEAD;
      ST_DEAD:  if (revive) state_d = ST_WALK;
      default:  state_d = ST_WALK;
    endcase
  end

  // Outputs decoded from registered state.
  always_comb begin
    alive   = 1'b0;
    visible = 1'b0;
    case (state_q)
      ST_WALK: begin
        alive   = 1'b1;
        visible = 1'b1;
      end
      ST_DYING: visible = ~death_cnt_q[2];
      default: ;
    endcase
  end

  assign horiz = (dir_q == DIR_RIGHT) || (dir_q == DIR_LEFT);
  assign fwd   = ((dir_q == DIR_RIGHT) || (dir_q == DIR_DOWN)) ^ wall_turn;
  assign mv    = horiz ? step(x_q, fwd, X_MIN, X_MAX) : step(y_q, fwd, Y_MIN, Y_MAX);

  // Latches, position, direction and death counter.
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    dir_d       = dir_q;
    hit_d       = hit_q;
    bomb_d      = bomb_q;
    death_cnt_d = death_cnt_q;
    done_d      = 1'b0;
    case (state_q)
      ST_WALK: begin
        if (startOfFrame) begin
          // Decision uses last frame's latches; this cycle's inputs start the new frame.
          hit_d  = wallCollision ? HitEdgeCode : 4'd0;
          bomb_d = bombCollision;
          if (bomb_q) begin
            death_cnt_d = '0;
          end else if (wall_turn || move_tick) begin
            if (horiz) x_d = mv[10:0];
            else       y_d = mv[10:0];
            if (wall_turn || mv[11]) dir_d = dir_t'(dir_q + 2'd1);
          end
        end else begin
          hit_d  = hit_q | (wallCollision ? HitEdgeCode : 4'd0);
          bomb_d = bomb_q | bombCollision;
        end
      end
      ST_DYING: begin
        hit_d  = '0;
        bomb_d = 1'b0;
        if (startOfFrame) begin
          if (death_last) done_d = 1'b1;
          else            death_cnt_d = death_cnt_q + 16'd1;
        end
      end
      ST_DEAD: begin
        hit_d  = '0;
        bomb_d = 1'b0;
        if (revive) begin
          x_d   = 11'(INIT_X);
          y_d   = 11'(INIT_Y);
          dir_d = dir_t'(2'(INIT_DIR));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      x_q         <= 11'(INIT_X);
      y_q         <= 11'(INIT_Y);
      dir_q       <= dir_t'(2'(INIT_DIR));
      hit_q       <= '0;
      bomb_q      <= 1'b0;
      death_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      dir_q       <= dir_d;
      hit_q       <= hit_d;
      bomb_q      <= bomb_d;
      death_cnt_q <= death_cnt_d;
      done_q      <= done_d;
    end
  end

  assign topLeftX  = x_q;
  assign topLeftY  = y_q;
  assign dir       = dir_q;
  assign deathDone = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_enemy_move_ctrl.sv
// Bench for enemy_move_ctrl: directed scenarios plus randomized traffic
// checked against a frame-level behavioural model.
module tb_enemy_move_ctrl;
  import enemy_pkg::*;

  localparam int INIT_X = 64, INIT_Y = 64, INIT_DIR = 0, SPEED = 1;
  localparam int MOVE_PERIOD = 2, DEATH_FRAMES = 32;
  localparam int X_MIN = 32, X_MAX = 576, Y_MIN = 32, Y_MAX = 416;

  // clock / reset
  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  logic        sof = 0, wall = 0, bomb = 0, rev = 0;
  logic [3:0]  hec = '0;
  logic [10:0] topLeftX, topLeftY;
  logic        visible, alive, deathDone;
  logic [1:0]  dir;
  state_t      dbg_state;

  enemy_move_ctrl dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .wallCollision(wall),
    .bombCollision(bomb), .HitEdgeCode(hec), .revive(rev),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .visible(visible), .alive(alive),
    .dir(dir), .deathDone(deathDone), .dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  // behavioural model
  typedef enum int {M_WALK, M_DYING, M_DEAD} mstate_e;
  mstate_e m_st;
  int      m_x, m_y, m_dir, m_phase, m_death;
  bit [3:0] m_hit;
  bit      m_bomb, m_done;
  int dx[4]  = '{1, 0, -1, 0};
  int dy[4]  = '{0, 1, 0, -1};
  int blk[4] = '{1, 0, 3, 2};

  function automatic void model_reset();
    m_st = M_WALK; m_x = INIT_X; m_y = INIT_Y; m_dir = INIT_DIR;
    m_phase = 0; m_death = 0; m_hit = 0; m_bomb = 0; m_done = 0;
  endfunction

  function automatic bit model_move(int sgn);
    int nx, ny;
    bit sat;
    sat = 0;
    nx = m_x + sgn * dx[m_dir] * SPEED;
    ny = m_y + sgn * dy[m_dir] * SPEED;
    if (nx > X_MAX) begin nx = X_MAX; sat = 1; end
    if (nx < X_MIN) begin nx = X_MIN; sat = 1; end
    if (ny > Y_MAX) begin ny = Y_MAX; sat = 1; end
    if (ny < Y_MIN) begin ny = Y_MIN; sat = 1; end
    m_x = nx; m_y = ny;
    return sat;
  endfunction

  function automatic void model_step(bit s, bit w, bit b, bit [3:0] h, bit r);
    m_done = 0;
    case (m_st)
      M_WALK: begin
        if (s) begin
          if (m_bomb) begin
            m_st = M_DYING; m_death = 0;
          end else if (m_hit[blk[m_dir]]) begin
            void'(model_move(-1));
            m_dir = (m_dir + 1) % 4;
            m_phase = 0;
          end else begin
            m_phase++;
            if (m_phase == MOVE_PERIOD) begin
              m_phase = 0;
              if (model_move(1)) m_dir = (m_dir + 1) % 4;
            end
          end
          m_hit = w ? h : 4'd0;
          m_bomb = b;
        end else begin
          if (w) m_hit = m_hit | h;
          m_bomb = m_bomb | b;
        end
      end
      M_DYING: begin
        m_hit = 0; m_bomb = 0;
        if (s) begin
          if (m_death == DEATH_FRAMES - 1) begin m_st = M_DEAD; m_done = 1; end
          else m_death++;
        end
      end
      default: begin
        m_hit = 0; m_bomb = 0;
        if (r) begin
          m_st = M_WALK; m_x = INIT_X; m_y = INIT_Y; m_dir = INIT_DIR; m_phase = 0;
        end
      end
    endcase
  endfunction

  function automatic bit exp_visible();
    if (m_st == M_WALK) return 1;
    if (m_st == M_DYING) return ((m_death / 4) % 2) == 0;
    return 0;
  endfunction

  // driver tasks
  task automatic drive(input bit s, input bit w, input bit b, input logic [3:0] h, input bit r);
    @(negedge clk);
    sof = s; wall = w; bomb = b; hec = h; rev = r;
    @(posedge clk);
    model_step(s, w, b, h, r);
    #1;
  endtask

  task automatic frame();
    drive(1, 0, 0, 4'd0, 0);
    drive(0, 0, 0, 4'd0, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    resetN = 0; sof = 0; wall = 0; bomb = 0; hec = 0; rev = 0;
    model_reset();
    repeat (2) @(negedge clk);
    resetN = 1;
    #1;
  endtask

  // scenarios
  task automatic test_reset();
    apply_reset();
    n_vec++; if (topLeftX !== 11'd64) begin n_err++; $display("FAIL reset_x: got %0d want 64", topLeftX); end
    n_vec++; if (topLeftY !== 11'd64) begin n_err++; $display("FAIL reset_y: got %0d want 64", topLeftY); end
    n_vec++; if (dir !== 2'd0) begin n_err++; $display("FAIL reset_dir: got %0d want 0", dir); end
    n_vec++; if (visible !== 1'b1) begin n_err++; $display("FAIL reset_visible: got %0b want 1", visible); end
    n_vec++; if (alive !== 1'b1) begin n_err++; $display("FAIL reset_alive: got %0b want 1", alive); end
    n_vec++; if (deathDone !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b want 0", deathDone); end
  endtask

  task automatic test_free_walk();
    repeat (4) frame();
    n_vec++; if (topLeftX !== 11'd66) begin n_err++; $display("FAIL walk_x: got %0d want 66", topLeftX); end
    n_vec++; if (topLeftY !== 11'd64) begin n_err++; $display("FAIL walk_y: got %0d want 64", topLeftY); end
    n_vec++; if (dir !== 2'd0 || visible !== 1'b1) begin n_err++; $display("FAIL walk_dir_vis: got %0d/%0b want 0/1", dir, visible); end
  endtask

  task automatic test_wall_turn();
    repeat (8) frame();
    n_vec++; if (topLeftX !== 11'd70) begin n_err++; $display("FAIL pre_turn_x: got %0d want 70", topLeftX); end
    drive(0, 1, 0, 4'b0010, 0);
    frame();
    n_vec++; if (topLeftX !== 11'd69 || dir !== 2'd1) begin n_err++; $display("FAIL turn_x_dir: got %0d/%0d want 69/1", topLeftX, dir); end
    frame();
    n_vec++; if (topLeftY !== 11'd64) begin n_err++; $display("FAIL turn_cnt_clear: got y=%0d want 64", topLeftY); end
    frame();
    n_vec++; if (topLeftY !== 11'd65) begin n_err++; $display("FAIL turn_next_move: got y=%0d want 65", topLeftY); end
    frame();
    drive(0, 1, 0, 4'b1000, 0);
    frame();
    n_vec++; if (topLeftY !== 11'd66 || dir !== 2'd1) begin n_err++; $display("FAIL side_hit: got y=%0d dir=%0d want 66/1", topLeftY, dir); end
  endtask

  task automatic test_same_cycle_wall();
    drive(1, 1, 0, 4'b0001, 0);
    drive(0, 0, 0, 4'd0, 0);
    n_vec++; if (topLeftY !== 11'd66 || dir !== 2'd1) begin n_err++; $display("FAIL sof_wall_no_turn: got y=%0d dir=%0d want 66/1", topLeftY, dir); end
    frame();
    n_vec++; if (topLeftY !== 11'd65 || dir !== 2'd2) begin n_err++; $display("FAIL sof_wall_late_turn: got y=%0d dir=%0d want 65/2", topLeftY, dir); end
  endtask

  task automatic test_bounds();
    apply_reset();
    for (int i = 0; i < 2 * (X_MAX - INIT_X); i++) begin
      frame();
      n_vec++; if (topLeftX !== 11'(m_x)) begin n_err++; $display("FAIL bound_walk_x: got %0d want %0d", topLeftX, m_x); end
    end
    n_vec++; if (topLeftX !== 11'd576 || dir !== 2'd0) begin n_err++; $display("FAIL at_xmax: got %0d/%0d want 576/0", topLeftX, dir); end
    repeat (2) frame();
    n_vec++; if (topLeftX !== 11'd576 || dir !== 2'd1) begin n_err++; $display("FAIL xmax_sat: got %0d/%0d want 576/1", topLeftX, dir); end
  endtask

  task automatic test_bomb_death();
    int  pulses;
    bit  ev;
    pulses = 0;
    apply_reset();
    repeat (4) frame();
    drive(0, 1, 1, 4'b0010, 0);
    drive(1, 0, 0, 4'd0, 0);
    n_vec++; if (alive !== 1'b0 || topLeftX !== 11'd66 || dir !== 2'd0) begin n_err++; $display("FAIL bomb_enter: got alive=%0b x=%0d dir=%0d want 0/66/0", alive, topLeftX, dir); end
    n_vec++; if (visible !== 1'b1) begin n_err++; $display("FAIL bomb_vis0: got %0b want 1", visible); end
    for (int k = 1; k <= DEATH_FRAMES; k++) begin
      drive(0, 1, 1, 4'b1111, k == 10);
      pulses += int'(deathDone);
      drive(1, 0, 0, 4'd0, 0);
      pulses += int'(deathDone);
      if (k < DEATH_FRAMES) begin
        ev = ((k / 8) * 8 + 4 > k) ? 1'b1 : 1'b0;
        n_vec++; if (visible !== ev) begin n_err++; $display("FAIL dying_vis k=%0d: got %0b want %0b", k, visible, ev); end
        n_vec++; if (alive !== 1'b0 || deathDone !== 1'b0) begin n_err++; $display("FAIL dying_alive k=%0d: got %0b/%0b want 0/0", k, alive, deathDone); end
      end else begin
        n_vec++; if (deathDone !== 1'b1 || visible !== 1'b0) begin n_err++; $display("FAIL dead_entry: got done=%0b vis=%0b want 1/0", deathDone, visible); end
      end
    end
    drive(1, 1, 1, 4'b1111, 0);
    pulses += int'(deathDone);
    n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL done_pulses: got %0d want 1", pulses); end
    n_vec++; if (visible !== 1'b0 || alive !== 1'b0 || topLeftX !== 11'd66) begin n_err++; $display("FAIL dead_hold: got vis=%0b alive=%0b x=%0d want 0/0/66", visible, alive, topLeftX); end
    drive(0, 0, 0, 4'd0, 1);
    n_vec++; if (topLeftX !== 11'd64 || topLeftY !== 11'd64 || dir !== 2'd0) begin n_err++; $display("FAIL revive_pos: got %0d,%0d dir %0d want 64,64 dir 0", topLeftX, topLeftY, dir); end
    n_vec++; if (visible !== 1'b1 || alive !== 1'b1) begin n_err++; $display("FAIL revive_flags: got %0b/%0b want 1/1", visible, alive); end
    frame();
    n_vec++; if (alive !== 1'b1) begin n_err++; $display("FAIL revive_latch_clear: got alive=%0b want 1", alive); end
  endtask

  task automatic test_reset_mid_dying();
    apply_reset();
    drive(0, 0, 1, 4'd0, 0);
    drive(1, 0, 0, 4'd0, 0);
    repeat (5) frame();
    n_vec++; if (alive !== 1'b0) begin n_err++; $display("FAIL pre_reset_dying: got alive=%0b want 0", alive); end
    @(posedge clk);
    #3 resetN = 0;
    model_reset();
    #1;
    n_vec++; if (topLeftX !== 11'd64 || topLeftY !== 11'd64 || dir !== 2'd0) begin n_err++; $display("FAIL async_reset_pos: got %0d,%0d dir %0d want 64,64 dir 0", topLeftX, topLeftY, dir); end
    n_vec++; if (visible !== 1'b1 || alive !== 1'b1 || deathDone !== 1'b0) begin n_err++; $display("FAIL async_reset_flags: got %0b/%0b/%0b want 1/1/0", visible, alive, deathDone); end
    @(negedge clk);
    resetN = 1;
    #1;
  endtask

  task automatic test_random();
    bit s, w, b, r;
    logic [3:0] h;
    for (int i = 0; i < 3000; i++) begin
      s = ($urandom_range(0, 3) == 0);
      w = ($urandom_range(0, 3) == 0);
      h = 4'($urandom_range(0, 15));
      b = ($urandom_range(0, 150) == 0);
      r = ($urandom_range(0, 15) == 0);
      drive(s, w, b, h, r);
      n_vec++; if (topLeftX !== 11'(m_x)) begin n_err++; $display("FAIL rnd_x @%0d: got %0d want %0d", i, topLeftX, m_x); end
      n_vec++; if (topLeftY !== 11'(m_y)) begin n_err++; $display("FAIL rnd_y @%0d: got %0d want %0d", i, topLeftY, m_y); end
      n_vec++; if (dir !== 2'(m_dir)) begin n_err++; $display("FAIL rnd_dir @%0d: got %0d want %0d", i, dir, m_dir); end
      n_vec++; if (visible !== exp_visible()) begin n_err++; $display("FAIL rnd_vis @%0d: got %0b want %0b", i, visible, exp_visible()); end
      n_vec++; if (alive !== (m_st == M_WALK)) begin n_err++; $display("FAIL rnd_alive @%0d: got %0b want %0b", i, alive, m_st == M_WALK); end
      n_vec++; if (deathDone !== m_done) begin n_err++; $display("FAIL rnd_done @%0d: got %0b want %0b", i, deathDone, m_done); end
    end
  endtask

  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL timeout: simulation exceeded time budget");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    model_reset();
    test_reset();
    test_free_walk();
    test_wall_turn();
    test_same_cycle_wall();
    test_bounds();
    test_bomb_death();
    test_reset_mid_dying();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
